// File: rtl/line_clipper_seq.sv
// rtl/line_clipper_seq.sv - multi-pass Cohen-Sutherland line clipper with valid/ready handshake
module line_clipper_seq #(
  parameter int W          = 12,
  parameter int MAX_PASSES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_x0,
  input  logic signed [W-1:0] in_y0,
  input  logic signed [W-1:0] in_x1,
  input  logic signed [W-1:0] in_y1,
  input  logic signed [W-1:0] win_xmin,
  input  logic signed [W-1:0] win_xmax,
  input  logic signed [W-1:0] win_ymin,
  input  logic signed [W-1:0] win_ymax,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_x0,
  output logic signed [W-1:0] out_y0,
  output logic signed [W-1:0] out_x1,
  output logic signed [W-1:0] out_y1,
  output logic                out_accept,
  output logic                busy
);

  localparam int NW = 2 * W + 2;
  localparam int PW = $clog2(MAX_PASSES + 1);
  localparam int CW = $clog2(NW);

  typedef enum logic [2:0] {S_IDLE, S_CODE, S_DIV, S_UPDATE, S_DONE} state_t;
  state_t state, state_next;

  logic signed [W-1:0] x0, y0, x1, y1, xmin, xmax, ymin, ymax;
  logic [PW-1:0]       pass_cnt;
  logic                accept;
  logic                sel_one;
  logic                y_edge_r;
  logic signed [W-1:0] bound_r;
  logic [W:0]          dmag;
  logic [W:0]          rem;
  logic [NW-1:0]       nq;
  logic                q_neg;
  logic [CW-1:0]       div_cnt;

  logic [3:0]           c0, c1;
  logic [2:0]           c_sel;
  logic                 y_edge, accept_now, reject_now;
  logic signed [W-1:0]  bnd;
  logic signed [W:0]    dx, dy, db, den;
  logic signed [NW-1:0] mul_a, mul_b, num;
  logic [NW-1:0]        num_mag;
  logic [W:0]           den_mag;
  logic [W+1:0]         trial;
  logic [W:0]           trial_sub;
  logic                 take;
  logic [W-1:0]         q_low;
  logic signed [W-1:0]  upd_val;

  function automatic logic [3:0] outcode(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                         input logic signed [W-1:0] xl, input logic signed [W-1:0] xh,
                                         input logic signed [W-1:0] yl, input logic signed [W-1:0] yh);
    outcode = {y > yh, y < yl, x > xh, x < xl};
  endfunction

  // Outcodes, edge choice, intersection operands, divider step and write-back value
  always_comb begin
    c0    = outcode(x0, y0, xmin, xmax, ymin, ymax);
    c1    = outcode(x1, y1, xmin, xmax, ymin, ymax);
    c_sel = (c0 != 4'd0) ? c0[3:1] : c1[3:1];
    accept_now = ((c0 | c1) == 4'd0);
    reject_now = ((c0 & c1) != 4'd0) || (pass_cnt == PW'(MAX_PASSES));
    y_edge = c_sel[2] | c_sel[1];
    if (c_sel[2])      bnd = ymax;
    else if (c_sel[1]) bnd = ymin;
    else if (c_sel[0]) bnd = xmax;
    else               bnd = xmin;
    dx = {x1[W-1], x1} - {x0[W-1], x0};
    dy = {y1[W-1], y1} - {y0[W-1], y0};
    if (y_edge) begin
      db    = {bnd[W-1], bnd} - {y0[W-1], y0};
      mul_a = NW'(dx);
      den   = dy;
    end else begin
      db    = {bnd[W-1], bnd} - {x0[W-1], x0};
      mul_a = NW'(dy);
      den   = dx;
    end
    mul_b   = NW'(db);
    num     = mul_a * mul_b;
    num_mag = num[NW-1] ? -num : num;
    den_mag = den[W] ? -den : den;
    trial     = {rem, nq[NW-1]};
    take      = (trial >= {1'b0, dmag});
    trial_sub = trial[W:0] - dmag;
    // Only the low W bits of base + quotient survive, so negate the low quotient bits alone
    q_low   = q_neg ? -nq[W-1:0] : nq[W-1:0];
    upd_val = (y_edge_r ? x0 : y0) + q_low;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = S_CODE;
      end
      S_CODE:   state_next = (accept_now || reject_now) ? S_DONE : S_DIV;
      S_DIV:    if (div_cnt == CW'(NW - 1)) state_next = S_UPDATE;
      S_UPDATE: state_next = S_CODE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: latch on input handshake, load divider in CODE, restoring step in DIV, write back in UPDATE
  always_ff @(posedge clk) begin
    if (rst) begin
      x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0;
      xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
      pass_cnt <= '0; accept <= 1'b0; sel_one <= 1'b0; y_edge_r <= 1'b0;
      bound_r <= '0; dmag <= '0; rem <= '0; nq <= '0; q_neg <= 1'b0; div_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x0 <= in_x0; y0 <= in_y0; x1 <= in_x1; y1 <= in_y1;
            xmin <= win_xmin; xmax <= win_xmax; ymin <= win_ymin; ymax <= win_ymax;
            pass_cnt <= '0;
          end
        end
        S_CODE: begin
          accept   <= accept_now;
          sel_one  <= (c0 == 4'd0);
          y_edge_r <= y_edge;
          bound_r  <= bnd;
          dmag     <= den_mag;
          nq       <= num_mag;
          q_neg    <= num[NW-1] ^ den[W];
          rem      <= '0;
          div_cnt  <= '0;
        end
        S_DIV: begin
          rem     <= take ? trial_sub : trial[W:0];
          nq      <= {nq[NW-2:0], take};
          div_cnt <= div_cnt + CW'(1);
        end
        S_UPDATE: begin
          pass_cnt <= pass_cnt + PW'(1);
          if (sel_one) begin
            x1 <= y_edge_r ? upd_val : bound_r;
            y1 <= y_edge_r ? bound_r : upd_val;
          end else begin
            x0 <= y_edge_r ? upd_val : bound_r;
            y0 <= y_edge_r ? bound_r : upd_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_x0     = x0;
  assign out_y0     = y0;
  assign out_x1     = x1;
  assign out_y1     = y1;
  assign out_accept = accept;

endmodule

// File: doc/line_clipper_seq.md
# line_clipper_seq

Multi-pass, pipelined-handshake Cohen–Sutherland line clipper for the 2D raster stage. It accepts one signed line segment and a runtime clip window per transaction. It iterates outcode evaluation and edge intersection until the segment is trivially accepted or rejected, then presents the clipped segment downstream. It generalises the single-edge combinational clip stage with parametrised coordinate width, runtime window bounds, a shared sequential divider, multi-edge iteration and valid/ready flow control.

## Interface
- W, 12: signed coordinate width in bits (two's complement) for all point and window values.
- MAX_PASSES, 4: maximum number of intersection passes before a forced reject.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input segment and window valid.
- in_ready  out  1  block can accept a segment; high only in IDLE.
- in_x0, in_y0, in_x1, in_y1  in  W each  endpoint 0 and endpoint 1.
- win_xmin, win_xmax, win_ymin, win_ymax  in  W each  inclusive clip window; requires xmin<=xmax and ymin<=ymax.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_x0, out_y0, out_x1, out_y1  out  W each  clipped endpoints.
- out_accept  out  1  1 means the segment is visible; 0 means rejected, and the coordinates are don't-care.
- busy  out  1  high in any state other than IDLE.

## Operation
- Outcode bits, MSB to LSB: TOP (y>ymax), BOTTOM (y<ymin), RIGHT (x>xmax), LEFT (x<xmin). All comparisons are signed.
- States: IDLE, CODE, DIV, UPDATE, DONE.
- IDLE: when in_valid and in_ready are both high, the block latches the endpoints and all four window bounds, clears the pass counter, and moves to CODE.
- CODE: computes c0 and c1 from the latched registers.
  - c0|c1==0: sets accept=1 and moves to DONE.
  - c0&c1!=0: sets accept=0 and moves to DONE.
  - pass counter == MAX_PASSES: sets accept=0 and moves to DONE.
  - Otherwise, picks the outside endpoint (endpoint 0 if c0!=0, else endpoint 1). It picks the edge by priority TOP > BOTTOM > RIGHT > LEFT, loads the divider, and moves to DIV.
- Intersection for the TOP/BOTTOM edge at bound B:
  - num = (x1-x0)*(B-y0), den = y1-y0.
  - x = x0 + num/den, and y = B.
  - RIGHT/LEFT is symmetric with x and y swapped.
  - Differences are W+1 bits wide; num is 2W+2 bits signed.
  - den is never 0 on this path, because the two endpoints have different outcodes on the chosen axis.
- DIV: a restoring divider on magnitudes produces 1 quotient bit per cycle, for 2W+2 cycles. The quotient truncates toward zero, and its sign is sign(num) XOR sign(den). No rounding is applied.
- UPDATE: the sum x0+q (or y0+q) is truncated to W bits. The block writes the intersection into the chosen endpoint register, increments the pass counter, and returns to CODE.
- DONE: out_valid=1 and the outputs come from the registers. When out_valid and out_ready are both high, the block moves to IDLE.
- Endpoint order is preserved: a clipped endpoint 0 stays on out_x0/out_y0.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, out_accept=0, and all out coordinates 0. Reset aborts any state, including mid-DIV, and the next cycle is IDLE.
- Handshake at edge E. CODE is active in cycle E+1, and out_valid rises after edge E+2 when no clip is needed.
- Latency from handshake to out_valid is 2 + N*(2W+4) cycles, where N is the number of passes (≤ MAX_PASSES). With W=12 this is 2 + 28N.
- in_ready=0 from the cycle after the input handshake until the cycle after the output handshake. There is no overlap between transactions, so throughput is one segment per transaction.
- While out_valid=1 and out_ready=0, all out_* signals hold stable.
- out_ready is ignored while out_valid=0.
- Window inputs are sampled only at the input handshake; changes mid-transaction have no effect.
- Degenerate segments (x0==x1 and y0==y1) resolve in CODE as either a trivial accept or a trivial reject.

## Test plan
W=12, window x 0..639, y 0..479.
- Trivial accept: (10,10)-(100,200) → out_valid at E+2, same coordinates, out_accept=1, no DIV cycles.
- Trivial reject: (-10,-5)-(-100,300), both LEFT → out_valid at E+2, out_accept=0.
- Single TOP clip: (100,100)-(100,600) → (100,100)-(100,479), accept=1, out_valid at E+30.
- Two clips: (-100,240)-(740,240) → (0,240)-(639,240), accept=1, out_valid at E+58.
- Truncation toward zero with a negative quotient:
  - (10,10)-(-3,0) → (10,10)-(0,3), since 10 + trunc(100/-13) = 3.
  - (-20,0)-(20,40) → (0,20)-(20,40).
- Flow control and reset:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0.
  - Assert rst during DIV → the next cycle has in_ready=1 and out_valid=0, and a new segment then completes correctly.
